rf_wb_arbiter: RTL

- Shares the register file's single write port (wr/addr3/data3) among NREQ write-back requesters: ALU, load unit and multiply/divide unit.
- Round-robin arbitration with a valid/ready handshake per requester; the granted write goes into a registered output stage that drives the RF write port.
- Writes to $0 are dropped here. Exports a one-hot in-flight mask for bypass and hazard logic.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/rf_wb_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and write-back requester indices.
package rf_pkg;

   localparam int RF_AW        = 5;
   localparam int RF_DW        = 32;
   localparam int RF_NREG      = 32;
   localparam int RF_ZERO_ADDR = 0;

   // Write-back requester slots on the shared RF write port
   localparam int WB_ALU = 0;
   localparam int WB_LSU = 1;
   localparam int WB_MDU = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Generic combinational round-robin grant: the first set request found
// searching upward from ptr (wrapping modulo NREQ) wins.
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   gnt_id,
   output logic            gnt_any
);

   int idx;

   // Priority search starting at ptr; only the first hit is granted
   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_id   = PW'(idx);
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single RF write port among write-back requesters using
// round-robin arbitration and a one-cycle registered output stage.
// Writes to $0 complete their handshake but never raise rf_wr.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int AW   = RF_AW,
   parameter int DW   = RF_DW
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*AW-1:0]       req_addr,
   input  logic [NREQ*DW-1:0]       req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     hold,
   output logic                     rf_wr,
   output logic [AW-1:0]            rf_addr,
   output logic [DW-1:0]            rf_data,
   output logic [2**AW-1:0]         inflight_mask,
   output logic [$clog2(NREQ)-1:0]  grant_id
);

   localparam int GW = $clog2(NREQ);

   logic [NREQ-1:0] gnt;
   logic [GW-1:0]   gnt_id;
   logic            gnt_any;
   logic            transfer;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   logic [GW-1:0]   rr_ptr_q,   rr_ptr_d;
   logic            rf_wr_q,    rf_wr_d;
   logic [AW-1:0]   rf_addr_q,  rf_addr_d;
   logic [DW-1:0]   rf_data_q,  rf_data_d;
   logic [GW-1:0]   grant_id_q, grant_id_d;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (GW)
   ) u_rr (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_any (gnt_any)
   );

   // Grants are suppressed during stall and while reset is held
   assign req_ready = (reset && !hold) ? gnt : '0;
   assign transfer  = |req_ready;
   assign sel_addr  = req_addr[int'(gnt_id)*AW +: AW];
   assign sel_data  = req_data[int'(gnt_id)*DW +: DW];

   // Next-state: capture the winner and advance the pointer past it
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      rf_wr_d    = 1'b0;
      rf_addr_d  = rf_addr_q;
      rf_data_d  = rf_data_q;
      grant_id_d = grant_id_q;
      if (transfer) begin
         rr_ptr_d   = (gnt_id == GW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
         rf_wr_d    = (sel_addr != AW'(RF_ZERO_ADDR));
         rf_addr_d  = sel_addr;
         rf_data_d  = sel_data;
         grant_id_d = gnt_id;
      end
   end

   // Pointer and output-stage registers; reset discards any staged write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_q   <= '0;
         rf_wr_q    <= 1'b0;
         rf_addr_q  <= '0;
         rf_data_q  <= '0;
         grant_id_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         rf_wr_q    <= rf_wr_d;
         rf_addr_q  <= rf_addr_d;
         rf_data_q  <= rf_data_d;
         grant_id_q <= grant_id_d;
      end
   end

   // One-hot of the destination currently heading into the RF
   always_comb begin
      inflight_mask = '0;
      if (rf_wr_q) inflight_mask[rf_addr_q] = 1'b1;
   end

   assign rf_wr    = rf_wr_q;
   assign rf_addr  = rf_addr_q;
   assign rf_data  = rf_data_q;
   assign grant_id = grant_id_q;

endmodule
